line_bus_engine: RTL and testbench

- Parametrised cache-line transfer engine between the L1 line buffers and the shared system bus.
- Handles both line writeback (store) and line fill (load) under one arbiter/bus handshake.
- Honours per-beat request backpressure (`main_bus_reqack`) and response tag matching.
- Line size and bus width are generic; one instance serves each cache port.

---
 rtl/line_bus_engine.sv | 120 ++++++++++++
 tb/tb_line_bus_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/line_bus_engine.sv
// Cache-line transfer engine: moves one line between the L1 line buffers and the
// shared system bus, as a writeback (store) or a fill (load), under one arbiter handshake.
module line_bus_engine #(
  parameter int unsigned                BUS_DATA_WIDTH = 64,
  parameter int unsigned                BUS_TAG_WIDTH  = 13,
  parameter int unsigned                LINE_BEATS     = 8,
  parameter logic [BUS_TAG_WIDTH-1:0]   TAG_WRITE      = 13'h1100,
  parameter logic [BUS_TAG_WIDTH-1:0]   TAG_READ       = 13'h0100
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 write_mode,
  input  logic [BUS_DATA_WIDTH-1:0]            addr,
  input  logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] wdata,
  output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] rdata,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 abtr_reqcyc,
  input  logic                                 abtr_grant,
  output logic                                 bus_busy,
  output logic                                 main_bus_reqcyc,
  input  logic                                 main_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0]            main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]             main_bus_reqtag,
  input  logic                                 main_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]            main_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]             main_bus_resptag,
  output logic                                 main_bus_respack
);

  localparam int unsigned OFFSET_BITS = $clog2(LINE_BEATS*BUS_DATA_WIDTH/8);
  localparam int unsigned IDX_BITS    = $clog2(LINE_BEATS);
  localparam int unsigned CNT_BITS    = IDX_BITS + 1;
  localparam logic [BUS_DATA_WIDTH-1:0] ALIGN_MASK =
    {{(BUS_DATA_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ADDR, S_WDATA, S_RDATA, S_DONE
  } state_t;

  state_t                    state, state_next;
  logic [CNT_BITS-1:0]       cnt;
  logic [IDX_BITS-1:0]       beat_idx;
  logic                      write_q;
  logic [BUS_DATA_WIDTH-1:0] addr_q;
  logic [BUS_DATA_WIDTH-1:0] line_q [LINE_BEATS];
  logic [BUS_DATA_WIDTH-1:0] fill_q [LINE_BEATS];
  logic                      resp_take;
  logic                      last_beat;

  assign beat_idx  = cnt[IDX_BITS-1:0];
  assign last_beat = (cnt == LAST_BEAT);
  // Foreign-tagged responses belong to another requester: never acked or captured.
  assign resp_take = (state == S_RDATA) && main_bus_respcyc && (main_bus_resptag == TAG_READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      for (int unsigned i = 0; i < LINE_BEATS; i++) fill_q[i] <= '0;
    end else begin
      state <= state_next;
      if (state == S_ADDR && main_bus_reqack)
        cnt <= '0;
      else if ((state == S_WDATA && main_bus_reqack) || resp_take)
        cnt <= cnt + 1'b1;
      if (resp_take) fill_q[beat_idx] <= main_bus_resp;
    end
  end

  // Request snapshot needs no reset: it is only observed after a start in IDLE.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      write_q <= write_mode;
      addr_q  <= addr & ALIGN_MASK;
      for (int unsigned i = 0; i < LINE_BEATS; i++)
        line_q[i] <= wdata[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_ARB;
      S_ARB:   if (abtr_grant) state_next = S_ADDR;
      S_ADDR:  if (main_bus_reqack) state_next = write_q ? S_WDATA : S_RDATA;
      S_WDATA: if (main_bus_reqack && last_beat) state_next = S_DONE;
      S_RDATA: if (resp_take && last_beat) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state != S_IDLE);
    done             = (state == S_DONE);
    abtr_reqcyc      = (state == S_ARB);
    bus_busy         = (state == S_ADDR) || (state == S_WDATA) || (state == S_RDATA);
    main_bus_reqcyc  = (state == S_ADDR) || (state == S_WDATA);
    main_bus_req     = '0;
    main_bus_reqtag  = '0;
    main_bus_respack = resp_take;
    if (state == S_ADDR) begin
      main_bus_req    = addr_q;
      main_bus_reqtag = write_q ? TAG_WRITE : TAG_READ;
    end else if (state == S_WDATA) begin
      main_bus_req    = line_q[beat_idx];
      main_bus_reqtag = TAG_WRITE;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < LINE_BEATS; i++)
      rdata[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = fill_q[i];
  end

endmodule

// File: tb/tb_line_bus_engine.sv
// Self-checking bench for line_bus_engine: directed table, hand-written reset and
// start-while-busy sequences, and randomized transfers against a line-level model.
module tb_line_bus_engine;

  localparam int BW  = 64;
  localparam int TW  = 13;
  localparam int LB  = 8;
  localparam int LW  = BW*LB;
  localparam int OFF = 6;
  localparam logic [TW-1:0] TWR  = 13'h1100;
  localparam logic [TW-1:0] TRD  = 13'h0100;
  localparam logic [TW-1:0] TFOR = 13'h0200;

  logic          clk = 1'b0;
  logic          reset, start, write_mode;
  logic [BW-1:0] addr;
  logic [LW-1:0] wdata, rdata;
  logic          busy, done, abtr_reqcyc, abtr_grant, bus_busy;
  logic          main_bus_reqcyc, main_bus_reqack, main_bus_respcyc, main_bus_respack;
  logic [BW-1:0] main_bus_req, main_bus_resp;
  logic [TW-1:0] main_bus_reqtag, main_bus_resptag;

  always #5 clk = ~clk;

  line_bus_engine #(
    .BUS_DATA_WIDTH(BW), .BUS_TAG_WIDTH(TW), .LINE_BEATS(LB),
    .TAG_WRITE(TWR), .TAG_READ(TRD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .write_mode(write_mode), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .abtr_reqcyc(abtr_reqcyc), .abtr_grant(abtr_grant), .bus_busy(bus_busy),
    .main_bus_reqcyc(main_bus_reqcyc), .main_bus_reqack(main_bus_reqack),
    .main_bus_req(main_bus_req), .main_bus_reqtag(main_bus_reqtag),
    .main_bus_respcyc(main_bus_respcyc), .main_bus_resp(main_bus_resp),
    .main_bus_resptag(main_bus_resptag), .main_bus_respack(main_bus_respack)
  );

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [LW-1:0] model_rdata;

  typedef struct {
    bit            wr;
    logic [BW-1:0] a;
    logic [BW-1:0] exp_a;
    int            gdelay;
    int            ack_mode;   // 0 always, 1 alternate, 2 random
    int            fmode;      // 0 none, 1 alternate foreign, 2 random
    int            exp_done;   // 0 = latency not checked
    bit            swb;        // pulse start while busy
  } vec_t;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    start = 0; write_mode = 0; addr = '0; abtr_grant = 0; main_bus_reqack = 0;
    main_bus_respcyc = 0; main_bus_resp = '0; main_bus_resptag = '0;
  endtask

  task automatic run_txn(input bit wr, input logic [BW-1:0] a, input logic [BW-1:0] exp_a,
                         input logic [LW-1:0] line, input logic [LW-1:0] fill,
                         input int gdelay, input int ack_mode, input int fmode,
                         input int exp_done, input bit swb, input string nm);
    logic [BW-1:0] bq[$];
    logic [TW-1:0] tq[$];
    int c = 0, done_cnt = 0, done_cyc = -1, arb_seen = 0, ridx = 0;
    int arb_bad = 0, hold_bad = 0, ack_bad = 0, tag_bad = 0;
    bit prev_wait = 0, fsel = 0, fg, exp_ack;
    logic [BW-1:0] prev_req = '0;
    start = 1; write_mode = wr; addr = a; wdata = line;
    @(posedge clk); #1;
    start = 0; write_mode = ~wr; addr = rnd64(); wdata = ~line;
    while (c < 300 && !(done_cyc >= 0 && c >= done_cyc + 2)) begin
      @(negedge clk); c++;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (abtr_reqcyc && (main_bus_reqcyc || bus_busy)) arb_bad++;
      if (prev_wait && main_bus_req !== prev_req) hold_bad++;
      start = swb && busy;
      if (start) begin write_mode = $urandom_range(0, 1); addr = rnd64(); end
      abtr_grant = abtr_reqcyc && (arb_seen >= gdelay);
      if (abtr_reqcyc) arb_seen++;
      main_bus_reqack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
      if (main_bus_reqcyc && main_bus_reqack) begin
        bq.push_back(main_bus_req);
        tq.push_back(main_bus_reqtag);
      end
      prev_wait = main_bus_reqcyc && !main_bus_reqack;
      prev_req  = main_bus_req;
      main_bus_respcyc = 0;
      main_bus_resp    = rnd64();
      main_bus_resptag = $urandom_range(0, 1) ? TRD : TFOR;
      if (bus_busy && !main_bus_reqcyc && ridx < LB &&
          (fmode != 2 || $urandom_range(0, 2) != 0)) begin
        fg = (fmode == 1) ? fsel : (fmode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        fsel = ~fsel;
        main_bus_respcyc = 1;
        main_bus_resptag = fg ? TFOR : TRD;
        main_bus_resp    = fg ? rnd64() : fill[ridx*BW +: BW];
      end
      #1;
      exp_ack = main_bus_respcyc && (main_bus_resptag == TRD);
      if (main_bus_respack !== exp_ack) ack_bad++;
      if (exp_ack) ridx++;
    end
    idle_inputs();
    chk({nm, ".finished"}, done_cyc >= 0, 1);
    chk({nm, ".done_count"}, done_cnt, 1);
    if (exp_done > 0) chk({nm, ".done_cycle"}, done_cyc, exp_done);
    chk({nm, ".addr_beat"}, (bq.size() > 0) ? bq[0] : '1, exp_a);
    chk({nm, ".addr_tag"}, (tq.size() > 0) ? tq[0] : '1, wr ? TWR : TRD);
    if (wr) begin
      chk({nm, ".beat_count"}, bq.size(), LB + 1);
      for (int k = 0; k < LB; k++)
        chk($sformatf("%s.beat%0d", nm, k), (bq.size() > k + 1) ? bq[k+1] : '1, line[k*BW +: BW]);
      for (int k = 1; k < tq.size(); k++) if (tq[k] !== TWR) tag_bad++;
      chk({nm, ".data_tags"}, tag_bad, 0);
    end else begin
      chk({nm, ".req_count"}, bq.size(), 1);
      model_rdata = fill;
    end
    chk({nm, ".arb_exclusive"}, arb_bad, 0);
    chk({nm, ".req_hold"}, hold_bad, 0);
    chk({nm, ".respack"}, ack_bad, 0);
    chk({nm, ".rdata"}, rdata, model_rdata);
    chk({nm, ".idle_after"}, busy, 0);
  endtask

  vec_t          vt[7];
  logic [LW-1:0] pat_w, pat_f;
  int            dcnt;

  initial begin
    for (int k = 0; k < LB; k++) begin
      pat_w[k*BW +: BW] = 64'h11 * (k + 1);
      pat_f[k*BW +: BW] = 64'hA0 + k;
    end
    vt[0] = '{1, 64'h1234_567F,          64'h1234_5640,          0, 0, 0, 11, 0};
    vt[1] = '{1, 64'h1234_567F,          64'h1234_5640,          0, 1, 0, 20, 0};
    vt[2] = '{0, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000, 0, 0, 1, 18, 0};
    vt[3] = '{1, 64'h0000_0000_0000_ABCD, 64'h0000_0000_0000_ABC0, 5, 0, 0, 16, 0};
    vt[4] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 0, 0, 0, 11, 0};
    vt[5] = '{1, 64'h0000_0000_0000_003F, 64'h0,                   0, 0, 0, 11, 1};
    vt[6] = '{0, 64'h0000_0000_0000_0040, 64'h0000_0000_0000_0040, 2, 1, 0, 14, 0};

    idle_inputs();
    wdata = '0; reset = 1; model_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.ctrl", {busy, done, abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack}, 0);
    chk("reset.req", {main_bus_req, main_bus_reqtag}, 0);
    chk("reset.rdata", rdata, 0);
    reset = 0;

    for (int i = 0; i < 7; i++)
      run_txn(vt[i].wr, vt[i].a, vt[i].exp_a, pat_w ^ LW'(i), pat_f ^ LW'(i << 8),
              vt[i].gdelay, vt[i].ack_mode, vt[i].fmode, vt[i].exp_done, vt[i].swb,
              $sformatf("vec%0d", i));

    // Reset while beat 4 of a writeback is on the bus.
    start = 1; write_mode = 1; addr = 64'h2000; wdata = pat_w;
    @(posedge clk); #1; start = 0;
    abtr_grant = 1; main_bus_reqack = 1;
    repeat (7) @(negedge clk);
    chk("abort.beat4_on_bus", main_bus_req, pat_w[4*BW +: BW]);
    reset = 1;
    @(posedge clk); #1; reset = 0; idle_inputs();
    model_rdata = '0;
    @(negedge clk);
    chk("abort.ctrl", {busy, done, abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack}, 0);
    chk("abort.req", {main_bus_req, main_bus_reqtag}, 0);
    chk("abort.rdata", rdata, 0);
    dcnt = 0;
    repeat (4) begin @(negedge clk); if (done || busy) dcnt++; end
    chk("abort.quiet", dcnt, 0);
    run_txn(1, 64'h2000, 64'h2000, pat_w, '0, 0, 0, 0, 11, 0, "after_abort");

    for (int i = 0; i < 24; i++) begin
      logic [BW-1:0] ra;
      logic [LW-1:0] rl, rf;
      bit rw;
      ra = rnd64(); rw = 1'($urandom_range(0, 1));
      for (int k = 0; k < LB; k++) begin rl[k*BW +: BW] = rnd64(); rf[k*BW +: BW] = rnd64(); end
      run_txn(rw, ra, (ra >> OFF) << OFF, rl, rf, $urandom_range(0, 4), 2, 2, 0,
              1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
